snn_output_controller: RTL

Sequencer for a bank of NUM_NEURONS output-layer LIF neurons that share one 16-bit data bus.
- Boot: loads one bias word per neuron through per-neuron one-hot data_ready strobes, with boot_mode held high.
- Run: routes per-timestep input contributions to the addressed neuron, issues the single-cycle snn_clk tick, and counts each neuron's spikes.
- After TIMESTEPS ticks: reports the argmax neuron as the classification result.

---
 rtl/snn_output_controller_if.sv | 41 ++++
 rtl/snn_output_controller.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/snn_output_controller_if.sv
// Handshake and neuron-bus bundle between the output-layer sequencer and its environment.
// master = host/neuron side, slave = sequencer side.
interface snn_output_controller_if #(
    parameter int NUM_NEURONS = 10,
    parameter int CNT_W       = 8,
    parameter int IDX_W       = 4,
    parameter int DATA_W      = 16
);
    logic                     boot_req;
    logic                     start;
    logic                     cfg_valid;
    logic signed [DATA_W-1:0] cfg_data;
    logic                     cfg_ready;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic [IDX_W-1:0]         in_idx;
    logic                     in_last;
    logic                     in_ready;
    logic signed [DATA_W-1:0] neuron_din;
    logic [NUM_NEURONS-1:0]   neuron_dr;
    logic                     boot_mode;
    logic                     snn_clk;
    logic [NUM_NEURONS-1:0]   spikes_in;
    logic                     busy;
    logic                     done;
    logic [IDX_W-1:0]         class_idx;
    logic [CNT_W-1:0]         class_count;
    logic                     err;

    modport master (
        output boot_req, start, cfg_valid, cfg_data, in_valid, in_data, in_idx, in_last, spikes_in,
        input  cfg_ready, in_ready, neuron_din, neuron_dr, boot_mode, snn_clk, busy, done,
               class_idx, class_count, err
    );

    modport slave (
        input  boot_req, start, cfg_valid, cfg_data, in_valid, in_data, in_idx, in_last, spikes_in,
        output cfg_ready, in_ready, neuron_din, neuron_dr, boot_mode, snn_clk, busy, done,
               class_idx, class_count, err
    );
endinterface

// File: rtl/snn_output_controller.sv
// Sequencer for a bank of output-layer LIF neurons on a shared data bus: bias boot,
// per-timestep contribution routing, tick generation, spike counting and argmax.
module snn_output_controller #(
    parameter int NUM_NEURONS = 10,
    parameter int TIMESTEPS   = 16,
    parameter int CNT_W       = 8,
    parameter int IDX_W       = 4,
    parameter int DATA_W      = 16
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    snn_output_controller_if.slave bus
);
    localparam int                TS_W    = $clog2(TIMESTEPS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [IDX_W-1:0]  LAST_N  = IDX_W'(NUM_NEURONS - 1);
    localparam logic [TS_W-1:0]   LAST_TS = TS_W'(TIMESTEPS - 1);

    typedef enum logic [3:0] {
        IDLE, BOOT, BOOT_FLUSH, ACC, FLUSH, TICK, SAMPLE, ARGMAX, DONE
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] boot_k;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] best_idx;
    logic [CNT_W-1:0] best_cnt;
    logic [TS_W-1:0]  ts;
    logic [CNT_W-1:0] spk_cnt [NUM_NEURONS];

    logic             cfg_acc, in_acc, in_hit, last_boot, last_scan, ts_last, take;
    logic [IDX_W-1:0] win_idx;
    logic [CNT_W-1:0] win_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [NUM_NEURONS-1:0] one_hot(input logic [IDX_W-1:0] i);
        return {{(NUM_NEURONS-1){1'b0}}, 1'b1} << i;
    endfunction

    assign cfg_acc   = (state == BOOT) && bus.cfg_valid;
    assign in_acc    = (state == ACC) && bus.in_valid;
    assign in_hit    = (bus.in_idx <= LAST_N);
    assign last_boot = (boot_k == LAST_N);
    assign last_scan = (scan_idx == LAST_N);
    assign ts_last   = (ts == LAST_TS);

    // Strictly-greater replacement keeps ties on the lowest index.
    assign take    = spk_cnt[scan_idx] > best_cnt;
    assign win_idx = take ? scan_idx : best_idx;
    assign win_cnt = take ? spk_cnt[scan_idx] : best_cnt;

    always_ff @(posedge sys_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.boot_req)   state_nxt = BOOT;
                else if (bus.start) state_nxt = ACC;
            end
            BOOT:       if (cfg_acc && last_boot) state_nxt = BOOT_FLUSH;
            BOOT_FLUSH: state_nxt = IDLE;
            ACC:        if (in_acc && bus.in_last) state_nxt = FLUSH;
            FLUSH:      state_nxt = TICK;
            TICK:       state_nxt = SAMPLE;
            SAMPLE:     state_nxt = ts_last ? ARGMAX : ACC;
            ARGMAX:     if (last_scan) state_nxt = DONE;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.cfg_ready = (state == BOOT);
        bus.in_ready  = (state == ACC);
        bus.boot_mode = (state == BOOT) || (state == BOOT_FLUSH);
        bus.snn_clk   = (state == TICK);
        bus.busy      = (state != IDLE);
        bus.done      = (state == DONE);
    end

    // Strobes are single-cycle: neuron_dr defaults low and is only raised by an accepted word.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            bus.neuron_dr   <= '0;
            bus.neuron_din  <= '0;
            bus.err         <= 1'b0;
            bus.class_idx   <= '0;
            bus.class_count <= '0;
            boot_k          <= '0;
            ts              <= '0;
            scan_idx        <= '0;
            best_idx        <= '0;
            best_cnt        <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) spk_cnt[i] <= '0;
        end else begin
            bus.neuron_dr <= '0;
            if (cfg_acc) begin
                bus.neuron_din <= bus.cfg_data;
                bus.neuron_dr  <= one_hot(boot_k);
                boot_k         <= boot_k + IDX_W'(1);
            end
            if (in_acc) begin
                if (in_hit) begin
                    bus.neuron_din <= bus.in_data;
                    bus.neuron_dr  <= one_hot(bus.in_idx);
                end else begin
                    bus.err <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    boot_k <= '0;
                    if (bus.start && !bus.boot_req) begin
                        ts      <= '0;
                        bus.err <= 1'b0;
                        for (int i = 0; i < NUM_NEURONS; i++) spk_cnt[i] <= '0;
                    end
                end
                SAMPLE: begin
                    for (int i = 0; i < NUM_NEURONS; i++)
                        if (bus.spikes_in[i]) spk_cnt[i] <= sat_inc(spk_cnt[i]);
                    if (!ts_last) ts <= ts + TS_W'(1);
                    scan_idx <= '0;
                    best_idx <= '0;
                    best_cnt <= '0;
                end
                ARGMAX: begin
                    scan_idx <= scan_idx + IDX_W'(1);
                    best_idx <= win_idx;
                    best_cnt <= win_cnt;
                    if (last_scan) begin
                        bus.class_idx   <= win_idx;
                        bus.class_count <= win_cnt;
                    end
                end
                default: ;
            endcase
        end
    end

    a_tick_excl: assert property (@(posedge sys_clk) disable iff (rst)
        !(bus.snn_clk && (|bus.neuron_dr)));
endmodule
